// File: rtl/key_scanner.sv
// -----------------------------------------------------------------------------
// key_scanner
//   Scans an 8x8 key matrix one row at a time. Each row is driven for SETTLE
//   cycles, then its columns are captured into a snapshot and compared one
//   column per cycle against a 64-bit image of the last reported key states.
//   Every difference becomes a press/release event in an 8-deep FIFO.
//
// Ports
//   clk       : sole clock, rising edge
//   reset     : synchronous active-high reset
//   enable    : scan enable (examined only in IDLE and at row boundaries)
//   key_sel   : one-hot row drive, 8'h00 when no row is selected
//   key_val   : column states of the selected row (1 = pressed)
//   ev_valid  : event FIFO non-empty
//   ev_data   : head event {press, 1'b0, row[2:0], col[2:0]}
//   ev_ack    : pop head event
//   ev_count  : number of events held, 0..8
// -----------------------------------------------------------------------------
module key_scanner #(
   parameter int SETTLE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic [7:0] key_sel,
   input  logic [7:0] key_val,
   output logic       ev_valid,
   output logic [7:0] ev_data,
   input  logic       ev_ack,
   output logic [3:0] ev_count
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SELECT = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_SCAN   = 2'd3;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   logic [1:0]  state_r;
   logic [2:0]  row_r;
   logic [2:0]  col_r;
   logic [3:0]  settle_cnt_r;
   logic [7:0]  snap_r;
   logic [63:0] image_r;
   logic [7:0]  key_sel_r;

   logic [7:0]  fifo_mem_r [0:7];
   logic [2:0]  wr_ptr_r;
   logic [2:0]  rd_ptr_r;
   logic [3:0]  count_r;

   logic        scan_bit_s;
   logic        image_bit_s;
   logic        full_s;
   logic        push_s;
   logic        pop_s;
   logic [2:0]  next_row_s;

   function automatic logic [7:0] row_onehot(input logic [2:0] row);
      logic [7:0] base;
      base = 8'h01;
      return base << row;
   endfunction

   // Column compare, FIFO handshake decode and next-row computation
   always_comb begin
      scan_bit_s  = snap_r[col_r];
      image_bit_s = image_r[{row_r, col_r}];
      full_s      = (count_r == 4'd8);
      pop_s       = ev_ack && (count_r != 4'd0);
      next_row_s  = row_r + 3'd1;
      // A full FIFO blocks the push even if a pop frees a slot this cycle;
      // the image bit stays stale so the change is picked up on a later scan.
      if ((state_r == ST_SCAN) && (scan_bit_s != image_bit_s) && !full_s) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
   end

   // Scan sequencer: row drive, settle count, snapshot capture, column walk
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         row_r        <= 3'd0;
         col_r        <= 3'd0;
         settle_cnt_r <= 4'd0;
         snap_r       <= 8'h00;
         key_sel_r    <= 8'h00;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (enable) begin
                  state_r      <= ST_SELECT;
                  key_sel_r    <= row_onehot(row_r);
                  settle_cnt_r <= 4'd0;
               end else begin
                  key_sel_r    <= 8'h00;
               end
            end
            ST_SELECT: begin
               if (settle_cnt_r == SETTLE_LAST) begin
                  state_r      <= ST_SAMPLE;
               end else begin
                  settle_cnt_r <= settle_cnt_r + 4'd1;
               end
            end
            ST_SAMPLE: begin
               snap_r  <= key_val;
               col_r   <= 3'd0;
               state_r <= ST_SCAN;
            end
            ST_SCAN: begin
               if (col_r == 3'd7) begin
                  row_r <= next_row_s;
                  // Row boundary: the only place enable is looked at mid-scan.
                  if (enable) begin
                     state_r      <= ST_SELECT;
                     key_sel_r    <= row_onehot(next_row_s);
                     settle_cnt_r <= 4'd0;
                  end else begin
                     state_r      <= ST_IDLE;
                     key_sel_r    <= 8'h00;
                  end
               end else begin
                  col_r <= col_r + 3'd1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               key_sel_r <= 8'h00;
            end
         endcase
      end
   end

   // Image of last reported key states, updated only when an event is queued
   always_ff @(posedge clk) begin
      if (reset) begin
         image_r <= 64'd0;
      end else if (push_s) begin
         image_r[{row_r, col_r}] <= scan_bit_s;
      end else begin
         image_r <= image_r;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= 3'd0;
         rd_ptr_r <= 3'd0;
         count_r  <= 4'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + 3'd1;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 3'd1;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 4'd1;
            2'b01:   count_r <= count_r - 4'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage; contents need no reset because occupancy gates visibility
   always_ff @(posedge clk) begin
      if (push_s && !reset) begin
         fifo_mem_r[wr_ptr_r] <= {scan_bit_s, 1'b0, row_r, col_r};
      end
   end

   assign key_sel  = key_sel_r;
   assign ev_count = count_r;
   assign ev_valid = (count_r != 4'd0);
   assign ev_data  = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_key_scanner.sv
// -----------------------------------------------------------------------------
// tb_key_scanner
//   Directed bench for key_scanner with a registered key-matrix model.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_key_scanner;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [7:0] key_sel;
   logic [7:0] key_val;
   logic       ev_valid;
   logic [7:0] ev_data;
   logic       ev_ack;
   logic [3:0] ev_count;

   logic [7:0] matrix [0:7];

   int checks;
   int errors;

   key_scanner #(.SETTLE(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .key_sel  (key_sel),
      .key_val  (key_val),
      .ev_valid (ev_valid),
      .ev_data  (ev_data),
      .ev_ack   (ev_ack),
      .ev_count (ev_count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] matrix_read(input logic [7:0] sel);
      logic [7:0] v;
      v = 8'h00;
      for (int r = 0; r < 8; r++) begin
         if (sel[r]) v = v | matrix[r];
      end
      return v;
   endfunction

   // Registered matrix source: columns follow the row drive one cycle later
   always @(posedge clk) begin
      key_val <= matrix_read(key_sel);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wait_sel(input string tag, input logic [7:0] v, input int budget);
      int n;
      n = 0;
      while (key_sel !== v && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, {24'd0, key_sel}, {24'd0, v});
   endtask

   task automatic wait_nonzero(input int budget);
      int n;
      n = 0;
      while (key_sel === 8'h00 && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic measure_hold(output int n);
      logic [7:0] v;
      v = key_sel;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (key_sel === v && n < 100);
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] exp);
      check_eq({tag, "_valid"}, {31'd0, ev_valid}, 32'd1);
      check_eq(tag, {24'd0, ev_data}, {24'd0, exp});
      ev_ack = 1'b1;
      @(negedge clk);
      ev_ack = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      clk    = 1'b0;
      reset  = 1'b1;
      enable = 1'b0;
      ev_ack = 1'b0;
      checks = 0;
      errors = 0;
      for (int r = 0; r < 8; r++) matrix[r] = 8'h00;

      // Reset state
      wait_cycles(2);
      check_eq("rst_key_sel", {24'd0, key_sel}, 32'h00);
      check_eq("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
      check_eq("rst_ev_count", {28'd0, ev_count}, 32'd0);

      // Idle matrix: row walk 01..80,01 with 13-cycle hold, no events
      reset  = 1'b0;
      enable = 1'b1;
      wait_sel("first_row", 8'h01, 10);
      for (int r = 0; r < 8; r++) begin
         logic [7:0] exp_sel;
         exp_sel = 8'h01 << r;
         check_eq($sformatf("walk_sel_%0d", r), {24'd0, key_sel}, {24'd0, exp_sel});
         measure_hold(n);
         check_eq($sformatf("walk_hold_%0d", r), n, 32'd13);
      end
      check_eq("walk_wrap", {24'd0, key_sel}, 32'h01);
      check_eq("walk_no_ev", {31'd0, ev_valid}, 32'd0);

      // Single key row 2 col 5: one press, one release, no repeats
      matrix[2] = 8'h20;
      wait_cycles(220);
      check_eq("press_count", {28'd0, ev_count}, 32'd1);
      pop_expect("press_data", 8'h95);
      wait_cycles(220);
      check_eq("press_no_repeat", {28'd0, ev_count}, 32'd0);
      matrix[2] = 8'h00;
      wait_cycles(220);
      check_eq("release_count", {28'd0, ev_count}, 32'd1);
      pop_expect("release_data", 8'h15);
      wait_cycles(220);
      check_eq("release_no_repeat", {28'd0, ev_count}, 32'd0);

      // Full row 0 pressed: 8 events in column order, FIFO full
      matrix[0] = 8'hFF;
      wait_cycles(220);
      check_eq("row0_count", {28'd0, ev_count}, 32'd8);
      for (int i = 0; i < 8; i++) begin
         pop_expect($sformatf("row0_ev_%0d", i), 8'h80 + 8'(i));
      end
      check_eq("row0_drained", {28'd0, ev_count}, 32'd0);

      // 10 keys held across reset: saturate at 8, remaining 2 later
      matrix[5] = 8'h02;
      matrix[6] = 8'h80;
      do_reset();
      wait_cycles(220);
      check_eq("sat_count", {28'd0, ev_count}, 32'd8);
      wait_sel("sat_row0", 8'h01, 120);
      for (int i = 0; i < 8; i++) begin
         pop_expect($sformatf("sat_ev_%0d", i), 8'h80 + 8'(i));
      end
      wait_cycles(220);
      check_eq("late_count", {28'd0, ev_count}, 32'd2);
      pop_expect("late_ev_0", 8'hA9);
      pop_expect("late_ev_1", 8'hB7);
      wait_cycles(220);
      check_eq("total_ten", {28'd0, ev_count}, 32'd0);

      // Reset during scan of row 3 with 5 events queued
      for (int r = 0; r < 8; r++) matrix[r] = 8'h00;
      matrix[1] = 8'h1F;
      do_reset();
      wait_sel("mid_row3", 8'h08, 120);
      wait_cycles(7);
      check_eq("mid_queued", {28'd0, ev_count}, 32'd5);
      reset = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_sel", {24'd0, key_sel}, 32'h00);
      check_eq("mid_rst_valid", {31'd0, ev_valid}, 32'd0);
      check_eq("mid_rst_count", {28'd0, ev_count}, 32'd0);
      reset = 1'b0;
      wait_nonzero(10);
      check_eq("mid_restart_row0", {24'd0, key_sel}, 32'h01);
      wait_cycles(120);
      check_eq("mid_rescan_count", {28'd0, ev_count}, 32'd5);
      for (int i = 0; i < 5; i++) begin
         pop_expect($sformatf("mid_ev_%0d", i), 8'h88 + 8'(i));
      end

      // Enable dropped in SELECT of row 4: row completes, resume at row 5
      wait_sel("en_row4", 8'h10, 120);
      enable = 1'b0;
      measure_hold(n);
      check_eq("en_row4_hold", n, 32'd13);
      check_eq("en_idle_sel", {24'd0, key_sel}, 32'h00);
      wait_cycles(5);
      check_eq("en_idle_stay", {24'd0, key_sel}, 32'h00);
      enable = 1'b1;
      wait_nonzero(10);
      check_eq("en_resume_row5", {24'd0, key_sel}, 32'h20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
